// File: rtl/uart_alu_interface.sv
// Collects operand A, operand B and opcode bytes from the UART receiver, drives the ALU
// and hands the result to the UART transmitter. An inter-byte timeout drops partial frames.
module uart_alu_interface #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic [NB_DATA-1:0] o_alu_data_a,
  output logic [NB_DATA-1:0] o_alu_data_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_error
);

  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value;
    r = 0;
    while (v > 0) begin
      v = v >> 1;
      r = r + 1;
    end
    return r;
  endfunction

  localparam int CW = (TIMEOUT_CYCLES > 1) ? clogb2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {WAIT_A, WAIT_B, WAIT_OP, SEND, WAIT_TX} state_t;

  state_t          state, state_nxt;
  logic            rx_done_d, tx_done_d;
  logic [CW-1:0]   cnt;
  logic            byte_valid, tx_fin, counting, expire, abort;

  assign byte_valid = i_rx_done & ~rx_done_d;
  assign tx_fin     = i_tx_done & ~tx_done_d;
  assign counting   = (TIMEOUT_CYCLES != 0) &&
                      (state == WAIT_B || state == WAIT_OP || state == WAIT_TX);
  // Abort on the edge where the counter would reach TIMEOUT_CYCLES-1.
  assign expire     = counting && ((32'(cnt) + 32'd1) == 32'(TIMEOUT_CYCLES - 1));
  // A real event in the same cycle beats the timeout.
  assign abort      = expire && ((state == WAIT_TX) ? !tx_fin : !byte_valid);
  assign o_busy     = (state != WAIT_A);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= WAIT_A;
      rx_done_d <= 1'b1;
      tx_done_d <= 1'b1;
    end else begin
      state     <= state_nxt;
      rx_done_d <= i_rx_done;
      tx_done_d <= i_tx_done;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_A:  if (byte_valid) state_nxt = WAIT_B;
      WAIT_B:  if (byte_valid) state_nxt = WAIT_OP; else if (expire) state_nxt = WAIT_A;
      WAIT_OP: if (byte_valid) state_nxt = SEND;    else if (expire) state_nxt = WAIT_A;
      SEND:    state_nxt = WAIT_TX;
      WAIT_TX: if (tx_fin)     state_nxt = WAIT_A;  else if (expire) state_nxt = WAIT_A;
      default: state_nxt = WAIT_A;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt <= '0;
    end else if (!counting || byte_valid || state_nxt != state) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_alu_data_a <= '0;
      o_alu_data_b <= '0;
      o_alu_op     <= '0;
      o_tx_data    <= '0;
      o_tx_start   <= 1'b0;
      o_error      <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_error    <= abort;
      case (state)
        WAIT_A:  if (byte_valid) o_alu_data_a <= i_rx_data;
        WAIT_B:  if (byte_valid) o_alu_data_b <= i_rx_data;
        WAIT_OP: if (byte_valid) o_alu_op     <= i_rx_data[NB_OP-1:0];
        SEND: begin
          o_tx_data  <= i_alu_result;
          o_tx_start <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_interface.sv
// Directed bench: a default-timeout instance for the data path and a TIMEOUT_CYCLES=50
// instance for abort behaviour, both fed from the same UART-side stimulus.
module tb_uart_alu_interface;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       tx_done = 1'b0;

  logic [7:0] a, b, txd, alu_res;
  logic [5:0] op;
  logic       start, busy, err;
  logic [7:0] t_a, t_b, t_txd, t_alu_res;
  logic [5:0] t_op;
  logic       t_start, t_busy, t_err;

  int total = 0;
  int bad   = 0;
  int starts = 0;
  int excl_bad = 0;
  int n;
  int s0;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu(input logic [7:0] x, input logic [7:0] y, input logic [5:0] o);
    case (o)
      6'h20:   return x + y;
      6'h22:   return x - y;
      6'h24:   return x & y;
      6'h25:   return x | y;
      6'h26:   return x ^ y;
      default: return 8'h00;
    endcase
  endfunction

  assign alu_res   = alu(a, b, op);
  assign t_alu_res = alu(t_a, t_b, t_op);

  uart_alu_interface dut (
    .i_clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .i_tx_done(tx_done), .i_alu_result(alu_res),
    .o_alu_data_a(a), .o_alu_data_b(b), .o_alu_op(op), .o_tx_data(txd),
    .o_tx_start(start), .o_busy(busy), .o_error(err)
  );

  uart_alu_interface #(.TIMEOUT_CYCLES(50)) dut_to (
    .i_clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .i_tx_done(tx_done), .i_alu_result(t_alu_res),
    .o_alu_data_a(t_a), .o_alu_data_b(t_b), .o_alu_op(t_op), .o_tx_data(t_txd),
    .o_tx_start(t_start), .o_busy(t_busy), .o_error(t_err)
  );

  always @(negedge clk) begin
    if (start) starts <= starts + 1;
    if ((start && err) || (t_start && t_err)) excl_bad <= excl_bad + 1;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input int hold);
    @(negedge clk);
    rx_data = v;
    rx_done = 1'b1;
    repeat (hold) @(negedge clk);
    rx_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic tx_pulse();
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_done = 1'b0;
    tx_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_a", a, 8'h00);
    chk("rst_op", 8'(op), 8'h00);
    chk("rst_txd", txd, 8'h00);
    chk("rst_start", 8'(start), 8'h0);
    chk("rst_busy", 8'(busy), 8'h0);
    chk("rst_err", 8'(err), 8'h0);

    // Basic ADD frame with exact start-pulse timing
    send_byte(8'h05, 1);
    send_byte(8'h03, 1);
    @(negedge clk);
    rx_data = 8'h20;
    rx_done = 1'b1;
    @(negedge clk);
    chk("t1_a", a, 8'h05);
    chk("t1_b", b, 8'h03);
    chk("t1_op", 8'(op), 8'h20);
    chk("t1_start_e0", 8'(start), 8'h0);
    rx_done = 1'b0;
    @(negedge clk);
    chk("t1_start_e1", 8'(start), 8'h1);
    chk("t1_txd", txd, 8'h08);
    @(negedge clk);
    chk("t1_start_e2", 8'(start), 8'h0);
    chk("t1_busy_wait", 8'(busy), 8'h1);
    tx_done = 1'b1;
    @(negedge clk);
    chk("t1_busy_fall", 8'(busy), 8'h0);
    tx_done = 1'b0;

    // Long rx_done levels: one capture per rise
    s0 = starts;
    send_byte(8'h11, 500);
    chk("t2_a", a, 8'h11);
    chk("t2_b_hold", b, 8'h03);
    chk("t2_busy", 8'(busy), 8'h1);
    send_byte(8'h22, 500);
    send_byte(8'h20, 500);
    chk("t2_b", b, 8'h22);
    chk("t2_txd", txd, 8'h33);
    chk("t2_starts", 8'(starts - s0), 8'd1);
    tx_pulse();
    chk("t2_idle", 8'(busy), 8'h0);

    // Byte during WAIT_TX is dropped
    send_byte(8'h09, 1);
    send_byte(8'h04, 1);
    send_byte(8'h22, 1);
    chk("t3_txd", txd, 8'h05);
    send_byte(8'h77, 1);
    chk("t3_drop_a", a, 8'h09);
    chk("t3_drop_b", b, 8'h04);
    chk("t3_busy", 8'(busy), 8'h1);
    tx_pulse();
    send_byte(8'h10, 1);
    send_byte(8'h01, 1);
    send_byte(8'h22, 1);
    chk("t3_a", a, 8'h10);
    chk("t3_txd2", txd, 8'h0F);
    tx_pulse();

    // Asynchronous reset mid-frame, released with rx_done high
    send_byte(8'h31, 1);
    send_byte(8'h32, 1);
    chk("t4_b_pre", b, 8'h32);
    @(negedge clk);
    #2 rst = 1'b1;
    rx_data = 8'h44;
    rx_done = 1'b1;
    #1;
    chk("t4_async_a", a, 8'h00);
    chk("t4_async_b", b, 8'h00);
    chk("t4_async_busy", 8'(busy), 8'h0);
    chk("t4_async_txd", txd, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_no_capture_busy", 8'(busy), 8'h0);
    chk("t4_no_capture_a", a, 8'h00);
    rx_done = 1'b0;
    send_byte(8'h06, 1);
    send_byte(8'h07, 1);
    send_byte(8'h24, 1);
    chk("t4_a", a, 8'h06);
    chk("t4_txd", txd, 8'h06);
    tx_pulse();

    // Timeout abort in WAIT_B, 49 edges after the capture edge
    do_reset();
    @(negedge clk);
    rx_data = 8'hAA;
    rx_done = 1'b1;
    @(negedge clk);
    chk("t5_a", t_a, 8'hAA);
    chk("t5_busy", 8'(t_busy), 8'h1);
    rx_done = 1'b0;
    n = 0;
    while (n < 100 && !t_err) begin
      @(negedge clk);
      n++;
    end
    chk("t5_err_cycle", 8'(n), 8'd49);
    chk("t5_idle", 8'(t_busy), 8'h0);
    chk("t5_a_kept", t_a, 8'hAA);
    @(negedge clk);
    chk("t5_err_pulse", 8'(t_err), 8'h0);
    send_byte(8'h01, 1);
    send_byte(8'h02, 1);
    send_byte(8'h22, 1);
    chk("t5_a2", t_a, 8'h01);
    chk("t5_op2", 8'(t_op), 8'h22);
    chk("t5_txd", t_txd, 8'hFF);
    tx_pulse();
    chk("t5_done", 8'(t_busy), 8'h0);

    // Byte arriving on the expiry edge wins
    do_reset();
    @(negedge clk);
    rx_data = 8'hAA;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    repeat (48) @(negedge clk);
    rx_data = 8'h5B;
    rx_done = 1'b1;
    @(negedge clk);
    chk("t6_no_err", 8'(t_err), 8'h0);
    chk("t6_b", t_b, 8'h5B);
    chk("t6_busy", 8'(t_busy), 8'h1);
    rx_done = 1'b0;
    send_byte(8'h20, 1);
    chk("t6_txd", t_txd, 8'h05);

    // No tx done: WAIT_TX times out
    n = 0;
    while (n < 100 && !t_err) begin
      @(negedge clk);
      n++;
    end
    chk("t7_tx_timeout", 8'(n < 100), 8'h1);
    chk("t7_idle", 8'(t_busy), 8'h0);

    chk("excl_err_start", 8'(excl_bad), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
